// File: rtl/wb_select_pipe.sv
// Write-back source selector with load byte/half extension and a one-entry
// valid/ready output stage. Optional counters under `WB_STATS_EN.
module wb_select_pipe #(
  parameter int          WIDTH     = 32,
  parameter int          NSRC      = 8,
  parameter int          SEL_W     = 4,
  parameter logic [31:0] CONST_VAL = 32'h000000E3,
  parameter int          LOAD_SRC  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] data_flat,
  input  logic [2:0]            ext_mode,
  input  logic [1:0]            byte_off,
  input  logic [4:0]            dst_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [4:0]            out_dst,
  output logic                  sel_err,
`ifdef WB_STATS_EN
  output logic [31:0]           stat_xfer,
  output logic [31:0]           stat_stall,
`endif
  output logic                  dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; valid never depends on ready, and the payload is held stable
  // while valid is high and ready is low.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

  state_t             state_q, state_d;
  logic               accept;
  logic [SEL_W-2:0]   idx;
  logic               use_const, idx_bad, is_load;
  logic [WIDTH-1:0]   src_word, ext_word, result;

  assign idx       = sel[SEL_W-2:0];
  assign use_const = sel[SEL_W-1];
  assign idx_bad   = !use_const && ({1'b0, idx} >= SEL_W'(NSRC));
  assign is_load   = !use_const && ({1'b0, idx} == SEL_W'(LOAD_SRC));

  always_comb begin
    src_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if ({1'b0, idx} == SEL_W'(i)) src_word = data_flat[i*WIDTH +: WIDTH];
    end
  end

  generate
    if (WIDTH == 32) begin : g_ext
      logic [7:0]  lane8;
      logic [15:0] lane16;
      always_comb begin
        case (byte_off)
          2'd0:    lane8 = src_word[7:0];
          2'd1:    lane8 = src_word[15:8];
          2'd2:    lane8 = src_word[23:16];
          default: lane8 = src_word[31:24];
        endcase
        lane16 = byte_off[1] ? src_word[31:16] : src_word[15:0];
        case (ext_mode)
          3'b001:  ext_word = {{24{lane8[7]}}, lane8};
          3'b010:  ext_word = {24'h0, lane8};
          3'b011:  ext_word = {{16{lane16[15]}}, lane16};
          3'b100:  ext_word = {16'h0, lane16};
          default: ext_word = src_word;
        endcase
      end
    end else begin : g_noext
      assign ext_word = src_word;
    end
  endgenerate

  always_comb begin
    if (use_const)    result = CONST_W;
    else if (idx_bad) result = '0;
    else if (is_load) result = ext_word;
    else              result = src_word;
  end

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_dst  <= '0;
      sel_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= result;
        out_dst  <= dst_in;
        if (idx_bad) sel_err <= 1'b1;
      end
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_xfer  <= '0;
      stat_stall <= '0;
    end else begin
      if (out_valid && out_ready)  stat_xfer  <= stat_xfer + 32'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Parametrised write-back source selector for the 32-bit CPU datapath; next generation of the combinational memory-to-register mux.
- Selects among NSRC data sources or a fixed constant, applies load byte/half extension to the memory source, and registers the result in a one-entry output stage with valid/ready handshake, stall and flush.
- Sits between MEM and the register-file write port.

Parameters:
- WIDTH, 32, data width; load extension is defined only for WIDTH=32 and ext_mode is ignored otherwise.
- NSRC, 8, number of data sources, 2..2**(SEL_W-1).
- SEL_W, 4, selector width; MSB selects the constant.
- CONST_VAL, 32'h000000E3, value driven when sel MSB=1.
- LOAD_SRC, 1, source index to which ext_mode applies.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept
- sel  in  SEL_W  source select
- data_flat  in  NSRC*WIDTH  sources; source i occupies bits [i*WIDTH +: WIDTH]
- ext_mode  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned
- byte_off  in  2  address low bits for lane selection
- dst_in  in  5  destination register
- flush  in  1  discard held entry
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer (register file) accepts
- out_data  out  WIDTH  registered result
- out_dst  out  5  registered destination
- sel_err  out  1  sticky: out-of-range index accepted

Behaviour:
- Reset, async on reset_n low: out_valid=0, out_data=0, out_dst=0, sel_err=0.
- Reset mid-transfer drops the entry; there is no replay.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready && !flush; the result appears on out_data/out_valid in the next cycle (latency 1).
- Accept and drain in the same cycle gives a back-to-back transfer at full throughput.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready && !accept.
  - FULL -> FULL on out_ready && accept, which loads new data.
  - FULL && !out_ready: hold out_data/out_dst stable; in_ready=0.
- flush=1: next state EMPTY regardless of in_valid/out_ready; any input that cycle is not accepted; flush has priority over accept.
- Selection:
  - sel[SEL_W-1]=1 -> CONST_VAL (truncated or zero-extended to WIDTH), no extension.
  - Otherwise idx=sel[SEL_W-2:0].
  - idx<NSRC -> source idx.
  - idx>=NSRC -> 0, and sel_err sets on accept. sel_err clears only on reset.
- Extension, only when idx==LOAD_SRC and constant not selected:
  - Byte: lane = data[8*byte_off +: 8]; signed fills bits 31:8 with lane bit 7, unsigned fills with 0.
  - Half: lane = byte_off[1] ? data[31:16] : data[15:0]; byte_off[0] is ignored; fill bits 31:16 with sign or 0.
  - ext_mode 101..111 is treated as word.
- out_dst is dst_in captured at accept. dst 0 passes through unchanged; the register file handles $zero.

Optional Feature:
- Macro WB_STATS_EN.
- When defined: adds outputs stat_xfer (32) and stat_stall (32), both reset to 0.
  - stat_xfer increments on each out_valid && out_ready.
  - stat_stall increments each cycle with out_valid && !out_ready.
  - Both wrap 32'hFFFFFFFF -> 0.
  - flush does not clear them.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, sel_err=0, in_ready=1. Assert reset_n low while FULL -> out_valid=0 immediately, with no clock edge.
- sel=4'b1000, in_valid=1, out_ready=1 -> next cycle out_data=32'h000000E3, out_valid=1.
- Source 1 = 32'h1234_8A7F, sel=1:
  - ext 001, byte_off=1 -> out_data=32'hFFFF_FF8A.
  - ext 010, byte_off=1 -> 32'h0000_008A.
  - ext 011, byte_off=2 -> 32'h0000_1234.
  - ext 011, byte_off=0 -> 32'hFFFF_8A7F.
- Source 3 = 32'hDEAD_BEEF, sel=3, ext=001 -> 32'hDEAD_BEEF (extension not applied to non-LOAD_SRC sources).
- Backpressure:
  - Accept A; hold out_ready=0 for 3 cycles -> out_data stays A, in_ready=0.
  - Raise out_ready with B valid -> B appears the next cycle with no bubble.
  - With WB_STATS_EN: stat_stall=3, stat_xfer=1 after A drains.
- flush=1 while FULL with in_valid=1 -> next cycle out_valid=0 and the input is not captured.
- NSRC=6, sel=4'b0111 -> out_data=0, sel_err=1, and sel_err remains 1 after subsequent valid selects.
